// File: rtl/b2a_pkg.sv
// Shared constants and width helpers for the serial-to-symbol deserialiser.
package b2a_pkg;

    localparam int B2A_WIDTH = 7;
    localparam int B2A_DEPTH = 4;

    // Bits needed for a partial-symbol bit count of 0..width-1.
    function automatic int CNT_W(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    // Bits needed for a FIFO occupancy of 0..depth.
    function automatic int LVL_W(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/b2a_fifo.sv
// Synchronous first-word-fall-through FIFO: dout always shows the head entry.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module b2a_fifo
    import b2a_pkg::*;
#(
    parameter int WIDTH = B2A_WIDTH,
    parameter int DEPTH = B2A_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [LVL_W(DEPTH)-1:0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = LVL_W(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/b2a_deser.sv
// Serial bit stream to WIDTH-bit symbols, buffered in a small FWFT FIFO.
// Output handshake: out_data is meaningful whenever out_valid=1, and the head
// symbol is consumed on any rising edge where out_valid and out_ready are both 1;
// out_valid never depends combinationally on out_ready.
module b2a_deser
    import b2a_pkg::*;
#(
    parameter int WIDTH     = B2A_WIDTH,
    parameter int DEPTH     = B2A_DEPTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in,
    input  logic                     in_valid,
    input  logic                     clear,
    output logic [CNT_W(WIDTH)-1:0]  cnt,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LVL_W(DEPTH)-1:0]  level,
    output logic                     overflow
);

    localparam int CW = CNT_W(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] shifted;
    logic             take;
    logic             done;
    logic             pop;
    logic             full;
    logic             empty;

    // Shift register with the current bit merged in; this is also the completed symbol.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {sr[WIDTH-2:0], in};
        end else begin : g_lsb
            assign shifted = {in, sr[WIDTH-1:1]};
        end
    endgenerate

    // clear beats in_valid, so a bit arriving with clear is discarded.
    assign take      = in_valid & ~clear;
    assign done      = take & (cnt == CW'(WIDTH - 1));
    assign pop       = out_valid & out_ready;
    assign out_valid = ~empty;

    // Partial-symbol assembly and bit counting.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (in_valid) begin
            sr  <= shifted;
            cnt <= done ? '0 : cnt + 1'b1;
        end
    end

    // Sticky flag: a completed symbol found the FIFO full with no pop to make room.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (done && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    b2a_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (done),
        .din   (shifted),
        .pop   (pop),
        .dout  (out_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

endmodule

// File: tb/tb_b2a_deser.sv
// Bench for b2a_deser: an MSB-first and an LSB-first instance share one
// stimulus stream; a reference model predicts symbols and FIFO occupancy.
module tb_b2a_deser;

    localparam int W = 7;
    localparam int D = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst, in, in_valid, clear, out_ready;
    always #5 clk = ~clk;

    logic [2:0] cnt_m, cnt_l, lvl_m, lvl_l;
    logic [6:0] data_m, data_l;
    logic       valid_m, valid_l, ovf_m, ovf_l;

    b2a_deser #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clear(clear),
        .cnt(cnt_m), .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready),
        .level(lvl_m), .overflow(ovf_m)
    );

    b2a_deser #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clear(clear),
        .cnt(cnt_l), .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready),
        .level(lvl_l), .overflow(ovf_l)
    );

    // ---------------- reference model / scoreboard ----------------
    bit          bit_q[$];      // bits of the partial symbol, in arrival order
    logic [13:0] exp_q[$];      // {msb_first_symbol, lsb_first_symbol} held in the FIFO
    logic [13:0] got_q[$];      // symbols the consumer actually took
    int          m_lvl = 0;
    bit          m_ovf = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] rev7(input logic [6:0] s);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = s[6-i];
        return r;
    endfunction

    task automatic model_step();
        int lvl0;
        bit pop, push, acc;
        int vm, vl;
        if (rst) begin
            bit_q.delete();
            exp_q.delete();
            m_lvl = 0;
            m_ovf = 1'b0;
        end else begin
            lvl0 = m_lvl;
            pop  = (lvl0 > 0) && out_ready;
            push = 1'b0;
            vm   = 0;
            vl   = 0;
            if (clear) begin
                bit_q.delete();
            end else if (in_valid) begin
                bit_q.push_back(in);
                if (bit_q.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        vm = vm * 2 + int'(bit_q[i]);
                        vl = vl + int'(bit_q[i]) * (1 << i);
                    end
                    push = 1'b1;
                    bit_q.delete();
                end
            end
            acc = push && ((lvl0 < D) || pop);
            if (acc) exp_q.push_back({7'(vm), 7'(vl)});
            if (push && !acc) m_ovf = 1'b1;
            m_lvl = lvl0 - int'(pop) + int'(acc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: compare on the falling edge, pop the expectation when a handshake is pending.
    initial forever begin
        @(negedge clk);
        check("cnt_msb", cnt_m, bit_q.size());
        check("cnt_lsb", cnt_l, bit_q.size());
        check("level_msb", lvl_m, m_lvl);
        check("level_lsb", lvl_l, m_lvl);
        check("valid_msb", valid_m, m_lvl != 0);
        check("valid_lsb", valid_l, m_lvl != 0);
        check("ovf_msb", ovf_m, m_ovf);
        check("ovf_lsb", ovf_l, m_ovf);
        if (valid_m) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                check("data_msb", data_m, exp_q[0][13:7]);
                check("data_lsb", data_l, exp_q[0][6:0]);
                if (out_ready) begin
                    got_q.push_back({data_m, data_l});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic b, input logic v, input logic c);
        in = b;
        in_valid = v;
        clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_sym(input logic [6:0] s, input bit gap);
        for (int i = 6; i >= 0; i--) begin
            step(s[i], 1'b1, 1'b0);
            if (gap) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
    endtask

    task automatic check_got(input string name, input logic [6:0] exp_m);
        logic [13:0] g;
        if (got_q.size() == 0) begin
            check({name, "_delivered"}, 0, 1);
        end else begin
            g = got_q.pop_front();
            check({name, "_msb"}, g[13:7], exp_m);
            check({name, "_lsb"}, g[6:0], rev7(exp_m));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] s;
        rst = 1'b1; in = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_data_msb", data_m, 0);
        check("reset_data_lsb", data_l, 0);
        rst = 1'b0;

        // continuous stream "He"
        out_ready = 1'b1;
        got_q.delete();
        send_sym(7'h48, 1'b0);
        send_sym(7'h65, 1'b0);
        idle(3);
        check_got("H_cont", 7'h48);
        check_got("e_cont", 7'h65);

        // same stream with idle cycles between bits
        send_sym(7'h48, 1'b1);
        send_sym(7'h65, 1'b1);
        idle(3);
        check_got("H_gap", 7'h48);
        check_got("e_gap", 7'h65);

        // overflow: five symbols into a four-entry FIFO with no consumer
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) send_sym(7'(8'h41 + k), 1'b0);
        idle(1);
        check("full_level", lvl_m, 4);
        check("full_overflow", ovf_m, 1);
        out_ready = 1'b1;
        idle(6);
        for (int k = 0; k < 4; k++) check_got("drain", 7'(8'h41 + k));
        check("lost_symbol", got_q.size(), 0);

        // refill, then push and pop on the same edge while full
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_sym(7'(8'h50 + k), 1'b0);
        s = 7'h54;
        for (int i = 6; i >= 1; i--) step(s[i], 1'b1, 1'b0);
        out_ready = 1'b1;
        step(s[0], 1'b1, 1'b0);
        check("push_pop_full_level", lvl_m, 4);
        idle(6);
        for (int k = 0; k < 5; k++) check_got("refill", 7'(8'h50 + k));

        // clear mid-symbol, colliding with a valid bit
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("cnt_after_clear", cnt_m, 0);
        send_sym(7'h48, 1'b0);
        idle(3);
        check_got("after_clear", 7'h48);

        // reset mid-symbol with two entries buffered
        out_ready = 1'b0;
        send_sym(7'h11, 1'b0);
        send_sym(7'h22, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        check("pre_rst_cnt", cnt_m, 4);
        check("pre_rst_level", lvl_m, 2);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        check("rst_cnt", cnt_m, 0);
        check("rst_level", lvl_m, 0);
        check("rst_valid", valid_m, 0);
        check("rst_overflow", ovf_m, 0);
        out_ready = 1'b1;
        send_sym(7'h41, 1'b0);
        idle(3);
        check_got("after_rst", 7'h41);

        // randomized traffic with consumer stalls, clears and rare resets
        for (int seg = 0; seg < 8; seg++) begin
            for (int c = 0; c < 120; c++) begin
                rst = ($urandom_range(0, 299) == 0);
                out_ready = (seg % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                           : ($urandom_range(0, 5) == 0);
                step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 39) == 0));
            end
        end
        rst = 1'b0;
        out_ready = 1'b1;
        idle(10);
        check("final_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
